// File: rtl/flag_context_stack_pkg.sv
// rtl/flag_context_stack_pkg.sv - shared control definitions: flag indices and context entry layout
package flag_context_stack_pkg;

  localparam int Z_FLAG    = 0;
  localparam int C_FLAG    = 1;
  localparam int N_FLAG    = 2;
  localparam int V_FLAG    = 3;
  localparam int NUM_FLAGS = 4;

  // Context entry layout: {pc, ie, v, n, c, z}
  localparam int IE_POS = NUM_FLAGS;
  localparam int PC_OFS = NUM_FLAGS + 1;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic z,
    input logic c,
    input logic n,
    input logic v
  );
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[Z_FLAG] = z;
    f[C_FLAG] = c;
    f[N_FLAG] = n;
    f[V_FLAG] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_context_stack_lifo_regfile.sv
// rtl/flag_context_stack_lifo_regfile.sv - context register array, one write port and one async read port
module lifo_regfile #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read lets a same-cycle push reuse the slot being popped.
  assign rdata = mem[raddr];

endmodule

// File: rtl/flag_context_stack.sv
// rtl/flag_context_stack.sv - interrupt context save/restore LIFO driving flag, IE and PC restore strobes
module flag_context_stack
  import flag_context_stack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flag_z,
  input  logic                   flag_c,
  input  logic                   flag_n,
  input  logic                   flag_v,
  input  logic                   ie_in,
  input  logic [PC_W-1:0]        pc_in,
  input  logic                   err_clr,
  output logic [NUM_FLAGS-1:0]   flag_din,
  output logic                   flag_wr,
  output logic                   ie_dout,
  output logic                   ie_wr,
  output logic [PC_W-1:0]        pc_dout,
  output logic                   pc_wr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   err_ovf,
  output logic                   err_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PC_W + PC_OFS;

  logic [LW-1:0]        level_q;
  logic [LW-1:0]        level_nxt;
  logic                 strobe_q;
  logic [NUM_FLAGS-1:0] flag_q;
  logic                 ie_q;
  logic [PC_W-1:0]      pc_q;
  logic                 err_ovf_q;
  logic                 err_udf_q;

  logic                 do_pop;
  logic                 do_push;
  logic                 ovf_evt;
  logic                 udf_evt;
  logic [AW-1:0]        top_idx;
  logic [AW-1:0]        wr_idx;
  logic [EW-1:0]        wr_data;
  logic [EW-1:0]        rd_data;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A pop is served before a same-cycle push, so a full stack still accepts push+pop.
  assign do_pop  = pop & ~empty;
  assign udf_evt = pop & empty;
  assign do_push = push & (do_pop | ~full);
  assign ovf_evt = push & full & ~do_pop;

  assign top_idx = AW'(level_q - LW'(1));
  assign wr_idx  = do_pop ? top_idx : AW'(level_q);
  assign wr_data = {pc_in, ie_in, pack_flags(flag_z, flag_c, flag_n, flag_v)};

  always_comb begin
    level_nxt = level_q;
    if (do_push && !do_pop) begin
      level_nxt = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_nxt = level_q - LW'(1);
    end
  end

  lifo_regfile #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_idx),
    .wdata (wr_data),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q   <= '0;
      strobe_q  <= 1'b0;
      flag_q    <= '0;
      ie_q      <= 1'b0;
      pc_q      <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      level_q   <= level_nxt;
      strobe_q  <= do_pop;
      if (do_pop) begin
        flag_q <= rd_data[NUM_FLAGS-1:0];
        ie_q   <= rd_data[IE_POS];
        pc_q   <= rd_data[PC_OFS +: PC_W];
      end
      // A new error in the same cycle as err_clr keeps the bit set.
      err_ovf_q <= ovf_evt | (err_ovf_q & ~err_clr);
      err_udf_q <= udf_evt | (err_udf_q & ~err_clr);
    end
  end

  // Reset in the strobe cycle kills the pending restore immediately.
  assign flag_wr  = strobe_q & rst_n;
  assign ie_wr    = strobe_q & rst_n;
  assign pc_wr    = strobe_q & rst_n;
  assign flag_din = flag_q;
  assign ie_dout  = ie_q;
  assign pc_dout  = pc_q;
  assign level    = level_q;
  assign err_ovf  = err_ovf_q;
  assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_flag_context_stack.sv
// tb/tb_flag_context_stack.sv - scoreboard bench for flag_context_stack with a queue-based stack model
module tb_flag_context_stack;

  localparam int DEPTH = 4;
  localparam int PC_W  = 8;

  typedef logic [PC_W+4:0] ent_t;

  logic       clk;
  logic       rst_n;
  logic       push, pop, err_clr;
  logic       flag_z, flag_c, flag_n, flag_v, ie_in;
  logic [7:0] pc_in;
  logic [3:0] flag_din;
  logic       flag_wr, ie_dout, ie_wr, pc_wr;
  logic [7:0] pc_dout;
  logic [2:0] level;
  logic       full, empty, err_ovf, err_udf;

  int   tests = 0;
  int   fails = 0;
  ent_t st[$];
  ent_t exp_q[$];
  ent_t last_exp;
  bit   m_ovf, m_udf, m_popped;

  flag_context_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .ie_in(ie_in), .pc_in(pc_in), .err_clr(err_clr),
    .flag_din(flag_din), .flag_wr(flag_wr), .ie_dout(ie_dout), .ie_wr(ie_wr),
    .pc_dout(pc_dout), .pc_wr(pc_wr), .level(level), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every restore strobe must match the oldest outstanding expected pop.
  always @(negedge clk) begin
    if (rst_n && flag_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        last_exp = e;
        chk("flag_din", 32'(flag_din), 32'(e[3:0]));
        chk("ie_dout", 32'(ie_dout), 32'(e[4]));
        chk("pc_dout", 32'(pc_dout), 32'(e[12:5]));
        chk("ie_wr", 32'(ie_wr), 1);
        chk("pc_wr", 32'(pc_wr), 1);
      end
    end
  end

  task automatic step(input bit p, input bit q, input bit c, input ent_t e);
    bit ovf, udf;
    push = p; pop = q; err_clr = c;
    {pc_in, ie_in, flag_v, flag_n, flag_c, flag_z} = e;
    udf      = q && (st.size() == 0);
    m_popped = q && (st.size() > 0);
    if (m_popped) exp_q.push_back(st.pop_back());
    ovf = 1'b0;
    if (p) begin
      if (st.size() < DEPTH) st.push_back(e);
      else ovf = 1'b1;
    end
    m_ovf = ovf | (m_ovf & !c);
    m_udf = udf | (m_udf & !c);
    @(posedge clk); #1;
    push = 0; pop = 0; err_clr = 0;
    chk("level", 32'(level), 32'(st.size()));
    chk("full", 32'(full), 32'(st.size() == DEPTH));
    chk("empty", 32'(empty), 32'(st.size() == 0));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_udf", 32'(err_udf), 32'(m_udf));
    chk("flag_wr", 32'(flag_wr), 32'(m_popped));
  endtask

  function automatic ent_t mk(input logic [7:0] pc);
    ent_t e;
    e = ent_t'($urandom);
    e[12:5] = pc;
    return e;
  endfunction

  task automatic model_reset();
    st.delete(); exp_q.delete();
    m_ovf = 0; m_udf = 0; last_exp = '0;
  endtask

  initial begin
    rst_n = 0; push = 0; pop = 0; err_clr = 0;
    {pc_in, ie_in, flag_v, flag_n, flag_c, flag_z} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_strobes", 32'({flag_wr, ie_wr, pc_wr}), 0);
    chk("rst_data", 32'({flag_din, ie_dout, pc_dout}), 0);
    chk("rst_err", 32'({err_ovf, err_udf}), 0);
    rst_n = 1;

    // Round trip: z=1 c=0 n=1 v=0, ie=1, pc=0x3A
    step(1, 0, 0, {8'h3A, 1'b1, 4'b0101});
    step(0, 1, 0, '0);
    chk("rt_flag_din", 32'(flag_din), 32'h5);
    chk("rt_pc", 32'(pc_dout), 32'h3A);
    chk("rt_ie", 32'(ie_dout), 1);
    step(0, 0, 0, '0);

    // Nested depth and overflow
    for (int i = 1; i <= 4; i++) step(1, 0, 0, mk(8'(i * 16)));
    chk("nest_full", 32'(full), 1);
    step(1, 0, 0, mk(8'h50));
    chk("ovf_set", 32'(err_ovf), 1);
    chk("ovf_level", 32'(level), 4);
    step(0, 1, 0, '0);
    chk("ovf_pop_pc", 32'(pc_dout), 32'h40);
    step(0, 0, 1, '0);
    chk("ovf_clr", 32'(err_ovf), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    chk("nest_empty", 32'(empty), 1);
    chk("nest_last_pc", 32'(pc_dout), 32'h10);

    // Underflow: outputs hold the last replayed context
    step(0, 1, 0, '0);
    chk("udf_set", 32'(err_udf), 1);
    chk("udf_hold_pc", 32'(pc_dout), 32'(last_exp[12:5]));
    chk("udf_hold_flags", 32'(flag_din), 32'(last_exp[3:0]));
    step(0, 1, 1, '0);
    chk("udf_set_wins", 32'(err_udf), 1);
    step(0, 0, 1, '0);

    // Simultaneous push and pop
    step(1, 0, 0, mk(8'h10));
    step(1, 0, 0, mk(8'h20));
    step(1, 1, 0, mk(8'h99));
    chk("sim_replay", 32'(pc_dout), 32'h20);
    chk("sim_level", 32'(level), 2);
    step(0, 1, 0, '0);
    chk("sim_next", 32'(pc_dout), 32'h99);

    // Reset asserted in the strobe cycle
    pop = 1;
    @(posedge clk); #1;
    pop = 0; rst_n = 0;
    #1;
    chk("rstpop_strobe", 32'({flag_wr, ie_wr, pc_wr}), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    chk("rstpop_level", 32'(level), 0);
    chk("rstpop_data", 32'({flag_din, ie_dout, pc_dout}), 0);
    chk("rstpop_err", 32'({err_ovf, err_udf}), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 10, ent_t'($urandom));
    end
    while (st.size() > 0) step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
